d_pipe_reg: RTL and testbench
=============================

// Module: d_pipe_reg
// PURPOSE
//  Parametrised multi-stage register pipeline: WIDTH-bit data plus valid bit.
//  - Async reset; synchronous flush; stall/enable with selectable disable mode.
//  - Reports valid-stage occupancy.
//  - General delay/retiming element for datapaths; replaces single enable flops.
// PARAMETERS
//  WIDTH     8        data width in bits, >=1
//  DEPTH     4        number of stages, >=1; DEPTH=0 is an elaboration error ($error)
//  DIS_MODE  DIS_HOLD enable low: DIS_HOLD = hold all stages; DIS_CLEAR = clear all stages
//  RST_VAL   '0       WIDTH-bit value loaded into data registers on reset/clear
// PORTS
//  clk       in   1                    clock, rising edge
//  rst       in   1                    reset, asynchronous, active-low
//  enable    in   1                    advance pipeline this cycle
//  clear     in   1                    synchronous flush, priority over enable
//  d         in   WIDTH                input data
//  d_valid   in   1                    input data valid
//  q         out  WIDTH                data of last stage
//  q_valid   out  1                    valid of last stage
//  taps      out  DEPTH*WIDTH          all stage data, stage0 in [WIDTH-1:0]
//  occupancy out  $clog2(DEPTH+1)      count of valid stages, registered
// BEHAVIOUR
//  - Reset: rst=0 forces the following immediately, independent of clk:
//    - all data registers = RST_VAL; all valids = 0; occupancy = 0.
//    - Release is synchronous-safe: the first rising edge after rst=1 operates normally.
//  - Priority at each rising edge: clear > enable > disable-mode.
//  - clear=1: every stage data = RST_VAL, valid = 0, occupancy = 0; enable and d are ignored.
//  - enable=1, clear=0:
//    - stage0 <= {d, d_valid}; stage i <= stage i-1 for i = 1..DEPTH-1.
//    - Data shifts unconditionally, whether the word is valid or not.
//  - enable=0, clear=0:
//    - DIS_HOLD: all stages and occupancy hold.
//    - DIS_CLEAR: all stages = RST_VAL/valid 0 and occupancy = 0, same as clear.
//  - Latency: a word sampled at edge n appears on q/q_valid after edge n+DEPTH-1.
//    - This counts enabled edges only; held cycles do not count.
//  - q = stage[DEPTH-1] data and q_valid = stage[DEPTH-1] valid. No combinational path from d to q.
//  - Occupancy on an enabled edge: occ_next = occ + d_valid - valid[DEPTH-1].
//    - Always equals the popcount of the stage valids; range 0..DEPTH.
//    - It cannot wrap: in the full state with d_valid=1, one word exits as one enters, so it stays at DEPTH.
//  - DEPTH=1: a single registered flop; occupancy width is 1 bit.
//  - Reset asserted mid-stream: all in-flight words are lost and none reappears after release.
// STRUCTURE
//  - Package d_pipe_pkg holds:
//    - typedef enum logic {DIS_HOLD, DIS_CLEAR} dis_mode_e;
//    - function occ_w(depth) returning $clog2(depth+1), used for port sizing.
//  - Sub-module d_ff_stage holds one stage: WIDTH data + valid, with async rst and sync clr/en inputs.
//    - d_pipe_reg instantiates DEPTH of them in a generate loop.
//    - The occupancy counter lives in the top level.
// TESTING
//  1. Reset: with WIDTH=8, DEPTH=4, RST_VAL=8'hA5, drive rst=0 mid-clock.
//     -> immediately q=8'hA5, q_valid=0, occupancy=0, taps=32'hA5A5A5A5.
//  2. Enable=1 streaming d=1,2,3,4 all valid.
//     -> q=1 with q_valid=1 after the 4th edge; occupancy reads 1,2,3,4 and then stays 4.
//  3. DIS_HOLD: after the pipe is full, drop enable for 3 cycles.
//     -> q, taps and occupancy unchanged; on re-enable, order continues with no loss.
//  4. DIS_CLEAR: the same stall.
//     -> on the first disabled edge all valids=0, data=RST_VAL, occupancy=0.
//  5. Assert clear and enable together with d_valid=1.
//     -> clear wins: occupancy=0 and q_valid=0 on the next cycle.
//  6. Bubbles: inputs valid,invalid,valid,invalid.
//     -> q_valid toggles 1,0,1,0 from the 4th edge; occupancy never exceeds 2.
//     -> repeat with DEPTH=1: q follows d one edge later.

Source files
------------

// File: rtl/d_pipe_pkg.sv
// rtl/d_pipe_pkg.sv - shared types and sizing helper for the d_pipe_reg pipeline
//  dis_mode_e : behaviour of the pipeline while enable is low
//  occ_w()    : width of an occupancy counter able to hold 0..depth
package d_pipe_pkg;

    typedef enum logic {
        DIS_HOLD,
        DIS_CLEAR
    } dis_mode_e;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one pipeline stage: WIDTH data bits plus a valid bit
//  clk      in   rising-edge clock
//  rst      in   asynchronous active-low reset (data = RST_VAL, valid = 0)
//  clr      in   synchronous clear, priority over en
//  en       in   load d/d_valid on this edge
//  d        in   WIDTH data input
//  d_valid  in   valid input
//  q        out  WIDTH registered data
//  q_valid  out  registered valid
module d_ff_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q       <= RST_VAL;
            q_valid <= 1'b0;
        end else if (clr) begin
            q       <= RST_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/d_pipe_reg.sv
// rtl/d_pipe_reg.sv - parametrised DEPTH-stage data+valid register pipeline
//  clk        in   rising-edge clock
//  rst        in   asynchronous active-low reset
//  enable     in   advance the pipeline this cycle
//  clear      in   synchronous flush, priority over enable
//  d          in   WIDTH input data
//  d_valid    in   input valid
//  q          out  WIDTH data of the last stage
//  q_valid    out  valid of the last stage
//  taps       out  DEPTH*WIDTH data of every stage, stage0 in [WIDTH-1:0]
//  occupancy  out  registered count of valid stages, 0..DEPTH
module d_pipe_reg
    import d_pipe_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter dis_mode_e        DIS_MODE = DIS_HOLD,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [DEPTH*WIDTH-1:0]   taps,
    output logic [occ_w(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    // In DIS_CLEAR mode a disabled edge behaves exactly like clear, so both
    // collapse into a single flush term shared by every stage and the counter.
    logic flush;
    assign flush = clear || (!enable && (DIS_MODE == DIS_CLEAR));

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("d_pipe_reg: DEPTH must be >= 1");
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_d [DEPTH];
            logic             stage_v [DEPTH];

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                logic [WIDTH-1:0] in_d;
                logic             in_v;

                if (i == 0) begin : g_head
                    assign in_d = d;
                    assign in_v = d_valid;
                end else begin : g_body
                    assign in_d = stage_d[i-1];
                    assign in_v = stage_v[i-1];
                end

                d_ff_stage #(
                    .WIDTH   (WIDTH),
                    .RST_VAL (RST_VAL)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .clr     (flush),
                    .en      (enable),
                    .d       (in_d),
                    .d_valid (in_v),
                    .q       (stage_d[i]),
                    .q_valid (stage_v[i])
                );

                assign taps[i*WIDTH +: WIDTH] = stage_d[i];
            end

            assign q       = stage_d[DEPTH-1];
            assign q_valid = stage_v[DEPTH-1];

            // Incremental popcount: one word may enter and one may leave per
            // enabled edge, so the count stays within 0..DEPTH without wrapping.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    occupancy <= '0;
                end else if (flush) begin
                    occupancy <= '0;
                end else if (enable) begin
                    occupancy <= occupancy + OCC_W'(d_valid) - OCC_W'(stage_v[DEPTH-1]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_d_pipe_reg.sv
// tb/tb_d_pipe_reg.sv - scoreboard bench for d_pipe_reg (hold, clear and single-stage variants)
module tb_d_pipe_reg;
    import d_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_valid = 1'b0;

    logic [7:0]  q_h, q_c, q_1;
    logic        qv_h, qv_c, qv_1;
    logic [31:0] taps_h, taps_c;
    logic [7:0]  taps_1;
    logic [2:0]  occ_h, occ_c;
    logic [0:0]  occ_1;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_h[$];
    logic [7:0] exp_c[$];
    logic [7:0] exp_1[$];

    always #5 clk = ~clk;

    d_pipe_reg #(.WIDTH(8), .DEPTH(4), .DIS_MODE(DIS_HOLD), .RST_VAL(8'hA5)) u_hold (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .d(d), .d_valid(d_valid),
        .q(q_h), .q_valid(qv_h), .taps(taps_h), .occupancy(occ_h)
    );

    d_pipe_reg #(.WIDTH(8), .DEPTH(4), .DIS_MODE(DIS_CLEAR), .RST_VAL(8'hA5)) u_clr (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .d(d), .d_valid(d_valid),
        .q(q_c), .q_valid(qv_c), .taps(taps_c), .occupancy(occ_c)
    );

    d_pipe_reg #(.WIDTH(8), .DEPTH(1), .DIS_MODE(DIS_HOLD), .RST_VAL(8'hA5)) u_d1 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .d(d), .d_valid(d_valid),
        .q(q_1), .q_valid(qv_1), .taps(taps_1), .occupancy(occ_1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] act);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s: got word %0h with nothing expected", name, act);
    endtask

    // Monitor: a new word reaches q only on an enabled, non-cleared edge.
    always @(posedge clk) begin : mon
        logic adv;
        adv = rst && enable && !clear;
        #1;
        if (adv && qv_h === 1'b1) begin
            if (exp_h.size() == 0) unexpected("hold_q", q_h);
            else chk("hold_q", q_h, exp_h.pop_front());
        end
        if (adv && qv_c === 1'b1) begin
            if (exp_c.size() == 0) unexpected("clr_q", q_c);
            else chk("clr_q", q_c, exp_c.pop_front());
        end
        if (adv && qv_1 === 1'b1) begin
            if (exp_1.size() == 0) unexpected("d1_q", q_1);
            else chk("d1_q", q_1, exp_1.pop_front());
        end
    end

    typedef struct {
        bit       en;
        bit       clr;
        bit       dv;
        bit [7:0] dd;
        int       oh;
        int       oc;
        int       o1;
        bit       qvh;
        bit [2:0] push;   // [2] hold, [1] clear-mode, [0] depth-1
    } step_t;

    step_t tbl [28] = '{
        '{1,0,1,8'h01, 1,1,1,0, 3'b111},
        '{1,0,1,8'h02, 2,2,1,0, 3'b111},
        '{1,0,1,8'h03, 3,3,1,0, 3'b111},
        '{1,0,1,8'h04, 4,4,1,1, 3'b111},
        '{1,0,1,8'h05, 4,4,1,1, 3'b111},
        '{0,0,1,8'h09, 4,0,1,1, 3'b000},
        '{0,0,1,8'h09, 4,0,1,1, 3'b000},
        '{0,0,1,8'h09, 4,0,1,1, 3'b000},
        '{1,0,1,8'h06, 4,1,1,1, 3'b111},
        '{1,0,0,8'h00, 3,1,0,1, 3'b000},
        '{1,0,0,8'h00, 2,1,0,1, 3'b000},
        '{1,0,0,8'h00, 1,1,0,1, 3'b000},
        '{1,0,1,8'h07, 1,1,1,0, 3'b001},
        '{1,1,1,8'h08, 0,0,0,0, 3'b000},
        '{1,0,1,8'h10, 1,1,1,0, 3'b111},
        '{1,0,0,8'h11, 1,1,0,0, 3'b000},
        '{1,0,1,8'h12, 2,2,1,0, 3'b111},
        '{1,0,0,8'h13, 2,2,0,1, 3'b000},
        '{1,0,0,8'h00, 1,1,0,0, 3'b000},
        '{1,0,0,8'h00, 1,1,0,1, 3'b000},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000},
        '{1,0,1,8'h20, 1,1,1,0, 3'b001},
        '{1,0,1,8'h21, 2,2,1,0, 3'b001},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000},
        '{1,0,0,8'h00, 0,0,0,0, 3'b000}
    };

    initial begin
        // Reset asserted in the middle of a clock-high phase takes effect at once.
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_q",      q_h,    8'hA5);
        chk("rst_qvalid", qv_h,   1'b0);
        chk("rst_occ",    occ_h,  0);
        chk("rst_taps",   taps_h, 32'hA5A5A5A5);
        chk("rst_d1_q",   q_1,    8'hA5);

        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst     = 1'b1;
            enable  = tbl[i].en;
            clear   = tbl[i].clr;
            d_valid = tbl[i].dv;
            d       = tbl[i].dd;
            // Words in flight in the clear-mode pipe are discarded by the stall.
            if (i == 5) exp_c.delete();
            if (tbl[i].push[2]) exp_h.push_back(tbl[i].dd);
            if (tbl[i].push[1]) exp_c.push_back(tbl[i].dd);
            if (tbl[i].push[0]) exp_1.push_back(tbl[i].dd);

            @(posedge clk);
            #2;
            chk($sformatf("occ_hold[%0d]", i), occ_h, tbl[i].oh);
            chk($sformatf("occ_clr[%0d]", i),  occ_c, tbl[i].oc);
            chk($sformatf("occ_d1[%0d]", i),   occ_1, tbl[i].o1);
            chk($sformatf("qv_hold[%0d]", i),  qv_h,  tbl[i].qvh);

            if (i == 5) chk("clr_stall_taps", taps_c, 32'hA5A5A5A5);
            if (i == 6) chk("hold_stall_taps", taps_h, 32'h02030405);
            if (i == 13) chk("clear_taps", taps_h, 32'hA5A5A5A5);
            if (i == 23) begin
                rst = 1'b0;
                #1;
                chk("midrst_occ",   occ_h,  0);
                chk("midrst_qv",    qv_h,   1'b0);
                chk("midrst_taps",  taps_h, 32'hA5A5A5A5);
                chk("midrst_d1_qv", qv_1,   1'b0);
            end
        end

        @(negedge clk);
        enable  = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        chk("hold_drained", exp_h.size(), 0);
        chk("clr_drained",  exp_c.size(), 0);
        chk("d1_drained",   exp_1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
